// File: rtl/gate_bist.sv
// Purpose : truth-table self-test for one 2-input gate. Drives all four {a,b}
//           vectors, holds each for SETTLE cycles, samples the gate output and
//           compares it with the golden table TRUTH.
// Latency : done strobes 4*SETTLE cycles after the accepting start edge.
// Backpr. : no handshake. start is taken only in IDLE or in the DONE cycle
//           (which exits through the IDLE decision). A start during RUN is
//           dropped, not queued.
// Ports   : clk, reset (async, active-high), start -> request a run
//           dut_a/dut_b -> registered gate inputs; dut_out <- gate output
//           busy, done (1-cycle strobe), pass, fail_vec (first bad {a,b})
//           fail_cnt (mismatch count) only when GATE_BIST_ERRCNT_EN is defined
module gate_bist #(
  parameter int         SETTLE = 2,       // 1..15
  parameter logic [3:0] TRUTH  = 4'b1000  // bit i = expected out for {a,b}=i
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef GATE_BIST_ERRCNT_EN
  output logic [2:0] fail_cnt,
`endif
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state, state_n;
  logic [1:0] idx, idx_n;     // also the value driven onto {dut_a,dut_b}
  logic [3:0] cnt, cnt_n;
  logic       busy_n, done_n, pass_n, mis, mis_n;
  logic [1:0] fail_vec_n;
  logic       hit;
`ifdef GATE_BIST_ERRCNT_EN
  logic [2:0] fail_cnt_n;
`endif

  assign dut_a = idx[1];
  assign dut_b = idx[0];
  assign hit   = (dut_out != TRUTH[idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= 2'b00;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= 2'b00;
      mis      <= 1'b0;
`ifdef GATE_BIST_ERRCNT_EN
      fail_cnt <= 3'd0;
`endif
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      fail_vec <= fail_vec_n;
      mis      <= mis_n;
`ifdef GATE_BIST_ERRCNT_EN
      fail_cnt <= fail_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    busy_n     = busy;
    done_n     = 1'b0;
    pass_n     = pass;
    fail_vec_n = fail_vec;
    mis_n      = mis;
`ifdef GATE_BIST_ERRCNT_EN
    fail_cnt_n = fail_cnt;
`endif
    case (state)
      ST_RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          // sample edge for vector idx
          if (hit) begin
            if (!mis) fail_vec_n = idx;
            mis_n = 1'b1;
`ifdef GATE_BIST_ERRCNT_EN
            fail_cnt_n = fail_cnt + 3'd1;
`endif
          end
          if (idx != 2'd3) begin
            idx_n = idx + 2'd1;
            cnt_n = SETTLE_C;
          end else begin
            // last vector: its own comparison is folded into pass here
            state_n = ST_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = ~(mis | hit);
          end
        end
      end
      default: begin
        // IDLE, and the single DONE cycle which falls back to IDLE
        if (state == ST_DONE) state_n = ST_IDLE;
        if (start) begin
          state_n    = ST_RUN;
          idx_n      = 2'b00;
          cnt_n      = SETTLE_C;
          busy_n     = 1'b1;
          pass_n     = 1'b0;
          fail_vec_n = 2'b00;
          mis_n      = 1'b0;
`ifdef GATE_BIST_ERRCNT_EN
          fail_cnt_n = 3'd0;
`endif
        end
      end
    endcase
  end

endmodule
